// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target with a byte register file, fabric preload port and master-write strobe
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int REG_AW = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  inout  wire               sda,
  input  logic              upd_we,
  input  logic [REG_AW-1:0] upd_addr,
  input  logic [7:0]        upd_data,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR_S, ADDR_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_q, sda_q, scl_s, sda_s, scl_rise, scl_fall, start, stop;
  logic oe, rw, last_bit, i2c_we;
  logic [2:0] cnt;
  logic [6:0] sh, rd;
  logic [7:0] byte_in;
  logic [REG_AW-1:0] ptr, ptr_inc;
  logic [7:0] regs [2**REG_AW];
  assign sda = oe ? 1'b0 : 1'bz;
  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s && !scl_q;
  assign scl_fall = !scl_s && scl_q;
  assign start = scl_s && sda_q && !sda_s;
  assign stop = scl_s && !sda_q && sda_s;
  assign byte_in = {sh, sda_s};
  assign last_bit = scl_rise && cnt == 3'd7;
  assign ptr_inc = ptr + 1'b1;
  assign i2c_we = state == WR_DATA && last_bit && !start && !stop;
  assign busy = state != IDLE;
  // bus input synchronizers plus one history stage for edge detection; idle bus is high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  // protocol state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: START/STOP override everything, ACK slots end on the second scl_fall
  always_comb begin
    state_n = state;
    if (start) state_n = DEV_ADDR_S;
    else if (stop) state_n = IDLE;
    else
      case (state)
        DEV_ADDR_S: if (last_bit) state_n = byte_in[7:1] == DEV_ADDR ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK: if (scl_fall && oe) state_n = rw ? RD_DATA : REG_PTR;
        REG_PTR: if (last_bit) state_n = PTR_ACK;
        PTR_ACK: if (scl_fall && oe) state_n = WR_DATA;
        WR_DATA: if (last_bit) state_n = WR_ACK;
        WR_ACK: if (scl_fall && oe) state_n = WR_DATA;
        RD_DATA: if (scl_fall && cnt == 3'd7) state_n = RD_ACK;
        RD_ACK: state_n = scl_rise && sda_s ? WAIT_STOP : scl_fall ? RD_DATA : RD_ACK;
        default: ;
      endcase
  end
  // datapath: shifting, pointer, sda drive and write reporting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      oe <= 1'b0;
      rw <= 1'b0;
      cnt <= 3'd0;
      sh <= 7'd0;
      rd <= 7'd0;
      ptr <= '0;
      wr_strobe <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
    end else begin
      wr_strobe <= 1'b0;
      if (start || stop) begin
        oe <= 1'b0;
        cnt <= 3'd0;
      end else
        case (state)
          DEV_ADDR_S, REG_PTR, WR_DATA:
            if (scl_rise) begin
              sh <= byte_in[6:0];
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7 && state == DEV_ADDR_S) rw <= byte_in[0];
              if (cnt == 3'd7 && state == REG_PTR) ptr <= byte_in[REG_AW-1:0];
              if (cnt == 3'd7 && state == WR_DATA) begin
                wr_strobe <= 1'b1;
                wr_addr <= ptr;
                wr_data <= byte_in;
                ptr <= ptr_inc;
              end
            end
          ADDR_ACK, PTR_ACK, WR_ACK:
            if (scl_fall) begin
              oe <= !oe;
              if (oe && state == ADDR_ACK && rw) begin
                rd <= regs[ptr][6:0];
                oe <= !regs[ptr][7];
              end
            end
          RD_DATA:
            if (scl_fall) begin
              cnt <= cnt + 3'd1;
              rd <= {rd[5:0], 1'b0};
              oe <= cnt == 3'd7 ? 1'b0 : !rd[6];
            end
          RD_ACK:
            if (scl_fall) begin
              ptr <= ptr_inc;
              rd <= regs[ptr_inc][6:0];
              oe <= !regs[ptr_inc][7];
            end
          default: oe <= 1'b0;
        endcase
    end
  // register file: a same-cycle bus write to the same address overrides the fabric update
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= 8'h00;
    end else begin
      if (upd_we) regs[upd_addr] <= upd_data;
      if (i2c_we) regs[ptr] <= byte_in;
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master against a register-file reference model
module tb_i2c_target_regs;
  localparam int Q = 10;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0, upd_we = 1'b0;
  logic [6:0] upd_addr = 7'd0;
  logic [7:0] upd_data = 8'h00;
  wire sda;
  logic wr_strobe, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  int n_assert = 0, n_fail = 0, n_strobe = 0, n_low = 0;
  logic [7:0] model [128];
  logic [6:0] mptr = 7'd0;
  logic [7:0] wbuf [4];
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  i2c_target_regs dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .upd_we(upd_we), .upd_addr(upd_addr),
    .upd_data(upd_data), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );
  // count write strobes and cycles where the target pulls sda while the master releases it
  always @(posedge clk) begin
    if (wr_strobe) n_strobe++;
    if (!m_low && sda === 1'b0) n_low++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic m_start;
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask
  task automatic m_stop;
    m_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b0; tick(Q);
  endtask
  // one bus clock; optional fabric update pulse aligned to the cycle the target acts on this rise
  task automatic m_bit(input logic b, input logic upd, output logic s);
    m_low = !b; tick(Q); scl = 1'b1;
    if (upd) begin tick(2); upd_we = 1'b1; tick(1); upd_we = 1'b0; tick(Q - 3); end
    else tick(Q);
    s = sda; tick(Q); scl = 1'b0; tick(Q);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic upd, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], upd && i == 0, s);
    m_bit(1'b1, 1'b0, ack);
  endtask
  task automatic read_byte(input logic nack, input logic upd, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin m_bit(1'b1, upd && i == 6, s); b[i] = s; end
    m_bit(nack, 1'b0, s);
  endtask
  task automatic upd(input logic [6:0] a, input logic [7:0] d);
    upd_addr = a; upd_data = d; upd_we = 1'b1; tick(1); upd_we = 1'b0; model[a] = d;
  endtask
  task automatic wr_txn(input logic [6:0] p, input int n);
    logic a;
    int s0;
    s0 = n_strobe;
    m_start;
    send_byte(8'hD0, 1'b0, a); check("wr dev ack", a, 0);
    send_byte({1'b0, p}, 1'b0, a); check("wr ptr ack", a, 0);
    mptr = p;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], 1'b0, a); check("wr data ack", a, 0);
      check("wr_addr", wr_addr, mptr); check("wr_data", wr_data, wbuf[i]);
      model[mptr] = wbuf[i]; mptr = mptr + 7'd1;
    end
    m_stop;
    check("wr strobes", n_strobe - s0, n); check("wr busy end", busy, 0);
  endtask
  task automatic rd_txn(input logic [6:0] p, input int n, input logic set_ptr);
    logic a;
    logic [7:0] b;
    m_start;
    if (set_ptr) begin
      send_byte(8'hD0, 1'b0, a); check("rd dev ack w", a, 0);
      send_byte({1'b0, p}, 1'b0, a); check("rd ptr ack", a, 0);
      mptr = p; m_start;
    end
    send_byte(8'hD1, 1'b0, a); check("rd dev ack r", a, 0);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, 1'b0, b); check("rd data", b, model[mptr]);
      if (i < n - 1) mptr = mptr + 7'd1;
    end
    m_stop;
    check("rd busy end", busy, 0);
  endtask
  initial begin
    logic a;
    logic [7:0] b;
    int l0, s0, op, n;
    logic [6:0] p;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    tick(3);
    check("rst wr_strobe", wr_strobe, 0); check("rst busy", busy, 0);
    check("rst wr_addr", wr_addr, 0); check("rst wr_data", wr_data, 0); check("rst sda", sda, 1);
    rst = 1'b0; tick(5);
    wbuf[0] = 8'h00; wr_txn(7'h6B, 1);
    for (int i = 0; i < 8; i++) upd(7'h3B + 7'(i), 8'(8'h11 * (i + 1)));
    rd_txn(7'h3B, 8, 1'b1);
    upd_addr = 7'h42; upd_data = 8'hEE;
    m_start; send_byte(8'hD1, 1'b0, a); check("capt dev ack", a, 0);
    read_byte(1'b1, 1'b1, b); check("capt old byte", b, 8'h88); m_stop;
    model[7'h42] = 8'hEE;
    rd_txn(7'h42, 1, 1'b1);
    l0 = n_low;
    m_start; check("busy after start", busy, 1);
    send_byte(8'hD2, 1'b0, a); check("other addr nack", a, 1);
    m_stop; check("other addr no drive", n_low - l0, 0); check("other addr busy", busy, 0);
    rd_txn(7'h6B, 1, 1'b1);
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB; wr_txn(7'h7F, 2);
    rd_txn(7'h7F, 2, 1'b1);
    s0 = n_strobe;
    m_start; send_byte(8'hD0, 1'b0, a); send_byte(8'h30, 1'b0, a); mptr = 7'h30;
    for (int i = 0; i < 4; i++) m_bit(1'b1, 1'b0, a);
    m_stop;
    check("partial no strobe", n_strobe - s0, 0); check("partial busy", busy, 0);
    rd_txn(7'h00, 1, 1'b0);
    upd_addr = 7'h10; upd_data = 8'h5A;
    m_start; send_byte(8'hD0, 1'b0, a); send_byte(8'h10, 1'b0, a);
    send_byte(8'hC3, 1'b1, a); check("same addr ack", a, 0);
    upd_addr = 7'h12; upd_data = 8'h77;
    send_byte(8'h44, 1'b1, a); m_stop;
    model[7'h10] = 8'hC3; model[7'h11] = 8'h44; model[7'h12] = 8'h77;
    rd_txn(7'h10, 3, 1'b1);
    for (int k = 0; k < 8; k++) begin
      op = int'($urandom_range(0, 2)); p = 7'($urandom_range(0, 127)); n = int'($urandom_range(1, 3));
      if (op == 0) upd(p, 8'($urandom));
      else if (op == 1) begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        wr_txn(p, n);
      end else rd_txn(p, n, 1'($urandom_range(0, 1)));
    end
    upd(7'h20, 8'h00);
    m_start; send_byte(8'hD0, 1'b0, a); send_byte(8'h20, 1'b0, a); m_start;
    send_byte(8'hD1, 1'b0, a);
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    check("rd bit7 driven low", sda, 0);
    rst = 1'b1; #1;
    check("rst mid read sda", sda, 1);
    tick(2); rst = 1'b0;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    mptr = 7'd0;
    scl = 1'b0; tick(Q); m_stop;
    check("post rst busy", busy, 0);
    rd_txn(7'h3B, 2, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
